// File: rtl/alu_seq_exec.sv
// EX-stage execution unit: AND/OR/ADD/SUB in one cycle, SLL one bit per cycle.
// Handshake: start is sampled only in IDLE; busy covers EXEC/SHIFT; done pulses for the one IDLE cycle after completion.
module alu_seq_exec #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;

  logic [1:0]         r_state;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sreg;
  logic [SHAMT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;
  logic               r_done;

  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_alu;
  logic               w_legal;

  assign w_shamt = r_b[SHAMT_W-1:0];

  // SLL with shamt=0 completes here as a plain copy of A.
  always_comb begin
    w_alu   = '0;
    w_legal = 1'b1;
    case (r_op)
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a + ~r_b + WIDTH'(1);
      OP_SLL:  w_alu = r_a;
      default: begin
        w_alu   = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sreg    <= '0;
      r_count   <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= operation;
            r_a     <= a;
            r_b     <= b;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_op == OP_SLL && w_shamt != '0) begin
            r_sreg  <= r_a << 1;
            r_count <= w_shamt - SHAMT_W'(1);
            r_state <= S_SHIFT;
          end else begin
            r_result  <= w_alu;
            r_zero    <= (w_alu == '0);
            r_illegal <= ~w_legal;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (r_count == '0) begin
            r_result  <= r_sreg;
            r_zero    <= (r_sreg == '0);
            r_illegal <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_sreg  <= r_sreg << 1;
            r_count <= r_count - SHAMT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: vector table for single ops and shifts, plus
// hand sequences for start-while-busy, reset mid-shift and back-to-back starts.
module tb_alu_seq_exec;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  operation;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] result;
  logic        zero;
  logic        illegal;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq_exec #(.WIDTH(64), .SHAMT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .a(a), .b(b), .result(result), .zero(zero), .illegal(illegal),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_result;
    logic        exp_zero;
    logic        exp_illegal;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Pulse start for one edge, then count posedges until done (bounded).
  task automatic run_op(input logic [3:0] op, input logic [63:0] va, input logic [63:0] vb,
                        output int lat);
    @(negedge clk);
    operation = op; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom(); b = $urandom();
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int lat;
    int n_done;
    int done_cyc;

    vecs[0] = '{4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1};
    vecs[1] = '{4'b0110, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, 1};
    vecs[2] = '{4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1};
    vecs[3] = '{4'b1000, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64};
    vecs[4] = '{4'b1000, 64'd3, 64'd0, 64'd3, 1'b0, 1'b0, 1};
    vecs[5] = '{4'b0111, 64'hDEAD, 64'hBEEF, 64'd0, 1'b1, 1'b1, 1};
    vecs[6] = '{4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1};
    vecs[7] = '{4'b0001, 64'hA0, 64'h0B, 64'hAB, 1'b0, 1'b0, 1};
    vecs[8] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1};
    vecs[9] = '{4'b1000, 64'd3, 64'h41, 64'd6, 1'b0, 1'b0, 2};

    reset = 1'b0; start = 1'b0; operation = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_zero", {63'd0, zero}, 64'd1);
    chk("reset_illegal", {63'd0, illegal}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      chk($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].exp_zero});
      chk($sformatf("v%0d_illegal", i), {63'd0, illegal}, {63'd0, vecs[i].exp_illegal});
    end

    // Start while busy: an ADD request mid-shift must be dropped.
    @(negedge clk);
    operation = 4'b1000; a = 64'd5; b = 64'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; done_cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 3) begin operation = 4'b0010; a = 64'd1; b = 64'd2; start = 1'b1; end
      if (c == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin n_done++; done_cyc = c; end
    end
    chk("busy_start_done_count", 64'(n_done), 64'd1);
    chk("busy_start_done_cycle", 64'(done_cyc), 64'd11);
    chk("busy_start_result", result, 64'h1400);

    // Reset on the third cycle of an SLL by 20.
    @(negedge clk);
    operation = 4'b1000; a = 64'd1; b = 64'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_result", result, 64'd0);
    chk("midreset_zero", {63'd0, zero}, 64'd1);
    chk("midreset_done", {63'd0, done}, 64'd0);
    @(negedge clk); reset = 1'b1;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("midreset_no_done", 64'(n_done), 64'd0);

    // Illegal op, then an AND accepted in the done cycle.
    @(negedge clk);
    operation = 4'b1111; a = 64'h55; b = 64'h66; start = 1'b1;
    @(posedge clk); #1;
    operation = 4'b0000; a = 64'hF0; b = 64'h3C;
    @(posedge clk); #1;
    chk("illegal_done", {63'd0, done}, 64'd1);
    chk("illegal_flag", {63'd0, illegal}, 64'd1);
    chk("illegal_result", result, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", {63'd0, busy}, 64'd1);
    chk("b2b_done_low", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    chk("b2b_done", {63'd0, done}, 64'd1);
    chk("b2b_result", result, 64'h30);
    chk("b2b_illegal", {63'd0, illegal}, 64'd0);
    @(posedge clk); #1;
    chk("b2b_done_pulse", {63'd0, done}, 64'd0);
    chk("b2b_result_hold", result, 64'h30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
